ifu_litebpu: RTL and testbench
==============================

# ifu_litebpu

Static branch predictor and next-PC generator in the IFU, directly downstream of the IFU mini-decoder. It consumes the decoded branch/jump class, the jalr rs1 index and the branch immediate, and produces a taken prediction plus the predicted target for the fetch PC mux. For jalr with a general rs1 it runs a small dependency/read FSM against the register file, and stalls fetch until the target is known.

## Interface
- No parameters; widths come from the shared defines: `XLEN`=32, `PC_SIZE`=32, `RFIDX_WIDTH`=5.
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- f_valid  in  1  decoded instruction present; inputs below held stable while bpu_wait=1
- f_pc  in  PC_SIZE  PC of that instruction
- dec_bjp / dec_jal / dec_jalr  in  1 each  from mini-decoder; conditional branch = dec_bjp & ~dec_jal & ~dec_jalr
- dec_jalr_rs1idx  in  RFIDX_WIDTH  jalr base register index
- dec_bjp_imm  in  XLEN  sign-extended branch/jump offset
- flush  in  1  pipeline redirect; abort any FSM activity
- oitf_empty  in  1  no outstanding long-latency writebacks
- ir_valid, ir_rden  in  1 each  instruction in IR stage valid / writes rd
- ir_rdidx  in  RFIDX_WIDTH  its rd index
- rf_x1  in  XLEN  architectural x1, direct tap
- bpu2rf_rs1_ena  out  1  one-cycle read request on shared rs1 port
- bpu2rf_rs1_idx  out  RFIDX_WIDTH  = dec_jalr_rs1idx
- rf2bpu_rs1  in  XLEN  read data, valid the cycle after bpu2rf_rs1_ena
- bpu_wait  out  1  stall fetch; prediction not yet valid
- prdt_taken  out  1  predicted taken
- prdt_pc  out  PC_SIZE  predicted target

## Operation
- Prediction valid in any cycle with f_valid=1 and bpu_wait=0.
- Not bjp: prdt_taken=0, bpu_wait=0.
- Conditional branch: BTFN; prdt_taken = dec_bjp_imm[XLEN-1]; op1 = f_pc.
- jal: prdt_taken=1; op1 = f_pc.
- jalr: prdt_taken=1; op1 by rs1: x0 -> 0; x1 -> rf_x1; other (xn) -> rf2bpu_rs1 in DONE.
- prdt_pc = op1 + dec_bjp_imm, modulo 2^32 (wrap, no overflow flag); computed for every class, meaningful only when taken.
- x1 dependency: x1dep = ~oitf_empty | (ir_valid & ir_rden & ir_rdidx==1). jalr x1 with x1dep: bpu_wait=1 combinationally, no state change.
- xn dependency: xndep = ~oitf_empty | (ir_valid & ir_rden & ir_rdidx==dec_jalr_rs1idx).
- FSM (state encodings in defines), xn path only:
  - IDLE: f_valid & jalr xn & ~flush -> DEP if xndep else RD; bpu_wait=1.
  - DEP: bpu_wait=1; -> RD when ~xndep.
  - RD: bpu2rf_rs1_ena=1, bpu_wait=1; -> DONE.
  - DONE: bpu_wait=0, target from rf2bpu_rs1; -> IDLE.
- flush in any state -> IDLE next cycle, bpu2rf_rs1_ena forced 0 that cycle; f_valid=0 in DEP/RD also -> IDLE.
- bpu_wait=0 whenever f_valid=0.

## Timing
- Reset: state=IDLE, bpu2rf_rs1_ena=0; bpu_wait=0, prdt_taken=0 (f_valid low by IFU reset).
- Branch, jal, jalr x0, jalr x1 without dep: 0-cycle latency, combinational.
- jalr xn, no dep: cycle 0 IDLE/wait, cycle 1 RD/ena, cycle 2 DONE/result -> 2-cycle stall.
- jalr xn with dep: 2 cycles after dep clears.
- Back-to-back jalr xn: DONE -> IDLE then restarts; no overlap, ena never in consecutive cycles.
- Reset mid-FSM: immediate return to IDLE, ena drops asynchronously.

## Structure
- Shared defines: XLEN, PC_SIZE, RFIDX_WIDTH, and the 2-bit BPU state encodings (IDLE/DEP/RD/DONE).
- No sub-module: the FSM, dependency compare and one 32-bit adder live inline. RTL about 150 lines.

## Test plan
- bxx f_pc=0x80000100, imm=0xFFFFFFF0 -> prdt_taken=1, prdt_pc=0x800000F0, bpu_wait=0; imm=0x10 -> prdt_taken=0.
- jal f_pc=0xFFFFFFFC, imm=0x8 -> prdt_taken=1, prdt_pc=0x00000004 (wrap).
- jalr x1, rf_x1=0x80001000, imm=4, ir_valid=1/ir_rden=1/ir_rdidx=1 for 3 cycles -> bpu_wait=1 for 3 cycles, then prdt_pc=0x80001004.
- jalr x5, oitf_empty=1, no IR dep, rf2bpu_rs1=0x2000, imm=-4 -> ena in cycle 1 only with idx=5, cycle 2 bpu_wait=0, prdt_pc=0x1FFC.
- jalr x5 with oitf_empty=0 for 4 cycles -> DEP held 4 cycles, ena 1 cycle after clear, result next.
- flush in RD, and separately rst low in DEP -> IDLE, ena=0, no prediction emitted; next jalr x0 imm=0x100 -> prdt_pc=0x100 at 0 latency.

Source files
------------

// File: rtl/ifu_litebpu_pkg.sv
// Shared widths and BPU state encodings for the IFU static predictor.
package ifu_litebpu_pkg;

    localparam int XLEN        = 32;
    localparam int PC_SIZE     = 32;
    localparam int RFIDX_WIDTH = 5;

    typedef enum logic [1:0] {
        BPU_IDLE = 2'd0,
        BPU_DEP  = 2'd1,
        BPU_RD   = 2'd2,
        BPU_DONE = 2'd3
    } bpu_state_e;

endpackage

// File: rtl/ifu_litebpu.sv
// IFU static branch predictor: BTFN for branches, always-taken jumps,
// with a small rs1 dependency/read FSM for jalr through a general register.
module ifu_litebpu
    import ifu_litebpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   f_valid,
    input  logic [PC_SIZE-1:0]     f_pc,
    input  logic                   dec_bjp,
    input  logic                   dec_jal,
    input  logic                   dec_jalr,
    input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
    input  logic [XLEN-1:0]        dec_bjp_imm,
    input  logic                   flush,
    input  logic                   oitf_empty,
    input  logic                   ir_valid,
    input  logic                   ir_rden,
    input  logic [RFIDX_WIDTH-1:0] ir_rdidx,
    input  logic [XLEN-1:0]        rf_x1,
    output logic                   bpu2rf_rs1_ena,
    output logic [RFIDX_WIDTH-1:0] bpu2rf_rs1_idx,
    input  logic [XLEN-1:0]        rf2bpu_rs1,
    output logic                   bpu_wait,
    output logic                   prdt_taken,
    output logic [PC_SIZE-1:0]     prdt_pc
);

    bpu_state_e state_q;
    bpu_state_e state_d;

    logic           is_jal;
    logic           is_jalr;
    logic           is_bxx;
    logic           rs1_x0;
    logic           rs1_x1;
    logic           rs1_xn;
    logic           ir_wr;
    logic           x1dep;
    logic           xndep;
    logic           jalr_xn;
    logic           xn_wait;
    logic [XLEN-1:0] op1;

    assign is_jal  = dec_bjp & dec_jal;
    assign is_jalr = dec_bjp & dec_jalr;
    assign is_bxx  = dec_bjp & ~dec_jal & ~dec_jalr;

    assign rs1_x0 = (dec_jalr_rs1idx == RFIDX_WIDTH'(0));
    assign rs1_x1 = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
    assign rs1_xn = ~rs1_x0 & ~rs1_x1;

    assign ir_wr = ir_valid & ir_rden;
    assign x1dep = ~oitf_empty | (ir_wr & (ir_rdidx == RFIDX_WIDTH'(1)));
    assign xndep = ~oitf_empty | (ir_wr & (ir_rdidx == dec_jalr_rs1idx));

    assign jalr_xn = f_valid & is_jalr & rs1_xn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BPU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        xn_wait        = 1'b0;
        bpu2rf_rs1_ena = 1'b0;
        unique case (state_q)
            BPU_IDLE: begin
                if (jalr_xn) begin
                    xn_wait = 1'b1;
                    if (!flush) begin
                        state_d = xndep ? BPU_DEP : BPU_RD;
                    end
                end
            end
            BPU_DEP: begin
                xn_wait = 1'b1;
                if (flush || !f_valid) begin
                    state_d = BPU_IDLE;
                end else if (!xndep) begin
                    state_d = BPU_RD;
                end
            end
            BPU_RD: begin
                xn_wait        = 1'b1;
                bpu2rf_rs1_ena = ~flush;
                if (flush || !f_valid) begin
                    state_d = BPU_IDLE;
                end else begin
                    state_d = BPU_DONE;
                end
            end
            BPU_DONE: begin
                state_d = BPU_IDLE;
            end
        endcase
    end

    assign bpu2rf_rs1_idx = dec_jalr_rs1idx;

    // x1 has a direct tap, so its hazard only stalls and never touches the FSM
    assign bpu_wait = f_valid & (xn_wait | (is_jalr & rs1_x1 & x1dep));

    assign prdt_taken = f_valid & (is_jal | is_jalr | (is_bxx & dec_bjp_imm[XLEN-1]));

    always_comb begin
        op1 = f_pc;
        if (is_jalr) begin
            unique case (1'b1)
                rs1_x0: op1 = '0;
                rs1_x1: op1 = rf_x1;
                rs1_xn: op1 = rf2bpu_rs1;
            endcase
        end
    end

    assign prdt_pc = op1 + dec_bjp_imm;

endmodule

// File: tb/tb_ifu_litebpu.sv
// Directed self-checking bench for ifu_litebpu.
module tb_ifu_litebpu;
    import ifu_litebpu_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   f_valid;
    logic [PC_SIZE-1:0]     f_pc;
    logic                   dec_bjp;
    logic                   dec_jal;
    logic                   dec_jalr;
    logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx;
    logic [XLEN-1:0]        dec_bjp_imm;
    logic                   flush;
    logic                   oitf_empty;
    logic                   ir_valid;
    logic                   ir_rden;
    logic [RFIDX_WIDTH-1:0] ir_rdidx;
    logic [XLEN-1:0]        rf_x1;
    logic                   bpu2rf_rs1_ena;
    logic [RFIDX_WIDTH-1:0] bpu2rf_rs1_idx;
    logic [XLEN-1:0]        rf2bpu_rs1;
    logic                   bpu_wait;
    logic                   prdt_taken;
    logic [PC_SIZE-1:0]     prdt_pc;

    int total = 0;
    int bad   = 0;

    ifu_litebpu dut (
        .clk             (clk),
        .rst             (rst),
        .f_valid         (f_valid),
        .f_pc            (f_pc),
        .dec_bjp         (dec_bjp),
        .dec_jal         (dec_jal),
        .dec_jalr        (dec_jalr),
        .dec_jalr_rs1idx (dec_jalr_rs1idx),
        .dec_bjp_imm     (dec_bjp_imm),
        .flush           (flush),
        .oitf_empty      (oitf_empty),
        .ir_valid        (ir_valid),
        .ir_rden         (ir_rden),
        .ir_rdidx        (ir_rdidx),
        .rf_x1           (rf_x1),
        .bpu2rf_rs1_ena  (bpu2rf_rs1_ena),
        .bpu2rf_rs1_idx  (bpu2rf_rs1_idx),
        .rf2bpu_rs1      (rf2bpu_rs1),
        .bpu_wait        (bpu_wait),
        .prdt_taken      (prdt_taken),
        .prdt_pc         (prdt_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        f_valid = 1'b0;
        f_pc = '0;
        dec_bjp = 1'b0;
        dec_jal = 1'b0;
        dec_jalr = 1'b0;
        dec_jalr_rs1idx = '0;
        dec_bjp_imm = '0;
        flush = 1'b0;
        oitf_empty = 1'b1;
        ir_valid = 1'b0;
        ir_rden = 1'b0;
        ir_rdidx = '0;
        rf_x1 = '0;
        rf2bpu_rs1 = '0;

        #12;
        chk("rst_wait", 32'(bpu_wait), 32'd0);
        chk("rst_taken", 32'(prdt_taken), 32'd0);
        chk("rst_ena", 32'(bpu2rf_rs1_ena), 32'd0);
        rst = 1'b1;
        tick();

        // backward branch taken, forward not taken
        f_valid = 1'b1;
        dec_bjp = 1'b1;
        f_pc = 32'h8000_0100;
        dec_bjp_imm = 32'hFFFF_FFF0;
        #1;
        chk("bxx_back_taken", 32'(prdt_taken), 32'd1);
        chk("bxx_back_pc", prdt_pc, 32'h8000_00F0);
        chk("bxx_back_wait", 32'(bpu_wait), 32'd0);
        dec_bjp_imm = 32'h0000_0010;
        #1;
        chk("bxx_fwd_taken", 32'(prdt_taken), 32'd0);

        // jal with target wrap
        dec_jal = 1'b1;
        f_pc = 32'hFFFF_FFFC;
        dec_bjp_imm = 32'h0000_0008;
        #1;
        chk("jal_taken", 32'(prdt_taken), 32'd1);
        chk("jal_wrap_pc", prdt_pc, 32'h0000_0004);

        // non-branch instruction
        dec_bjp = 1'b0;
        dec_jal = 1'b0;
        #1;
        chk("nobjp_taken", 32'(prdt_taken), 32'd0);
        chk("nobjp_wait", 32'(bpu_wait), 32'd0);

        // jalr x1 blocked by IR writer for 3 cycles
        dec_bjp = 1'b1;
        dec_jalr = 1'b1;
        dec_jalr_rs1idx = 5'd1;
        rf_x1 = 32'h8000_1000;
        dec_bjp_imm = 32'd4;
        ir_valid = 1'b1;
        ir_rden = 1'b1;
        ir_rdidx = 5'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("x1dep_wait", 32'(bpu_wait), 32'd1);
            chk("x1dep_ena", 32'(bpu2rf_rs1_ena), 32'd0);
            tick();
        end
        ir_valid = 1'b0;
        #1;
        chk("x1_wait", 32'(bpu_wait), 32'd0);
        chk("x1_pc", prdt_pc, 32'h8000_1004);
        chk("x1_taken", 32'(prdt_taken), 32'd1);
        f_valid = 1'b0;
        tick();

        // jalr x5 without dependency
        f_valid = 1'b1;
        dec_jalr_rs1idx = 5'd5;
        rf2bpu_rs1 = 32'h0000_2000;
        dec_bjp_imm = 32'hFFFF_FFFC;
        #1;
        chk("xn_c0_wait", 32'(bpu_wait), 32'd1);
        chk("xn_c0_ena", 32'(bpu2rf_rs1_ena), 32'd0);
        tick();
        chk("xn_c1_ena", 32'(bpu2rf_rs1_ena), 32'd1);
        chk("xn_c1_idx", 32'(bpu2rf_rs1_idx), 32'd5);
        chk("xn_c1_wait", 32'(bpu_wait), 32'd1);
        tick();
        chk("xn_c2_wait", 32'(bpu_wait), 32'd0);
        chk("xn_c2_ena", 32'(bpu2rf_rs1_ena), 32'd0);
        chk("xn_c2_pc", prdt_pc, 32'h0000_1FFC);
        chk("xn_c2_taken", 32'(prdt_taken), 32'd1);
        f_valid = 1'b0;
        tick();

        // jalr x5 with oitf busy for 4 cycles
        f_valid = 1'b1;
        oitf_empty = 1'b0;
        #1;
        chk("dep_c0_wait", 32'(bpu_wait), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("dep_hold_wait", 32'(bpu_wait), 32'd1);
            chk("dep_hold_ena", 32'(bpu2rf_rs1_ena), 32'd0);
            tick();
        end
        oitf_empty = 1'b1;
        #1;
        chk("dep_clr_ena", 32'(bpu2rf_rs1_ena), 32'd0);
        chk("dep_clr_wait", 32'(bpu_wait), 32'd1);
        tick();
        chk("dep_rd_ena", 32'(bpu2rf_rs1_ena), 32'd1);
        tick();
        chk("dep_done_wait", 32'(bpu_wait), 32'd0);
        chk("dep_done_pc", prdt_pc, 32'h0000_1FFC);

        // back-to-back jalr x5: restart through IDLE
        tick();
        chk("b2b_idle_ena", 32'(bpu2rf_rs1_ena), 32'd0);
        chk("b2b_idle_wait", 32'(bpu_wait), 32'd1);
        tick();
        chk("b2b_rd_ena", 32'(bpu2rf_rs1_ena), 32'd1);
        tick();
        chk("b2b_done_wait", 32'(bpu_wait), 32'd0);
        f_valid = 1'b0;
        tick();

        // flush while in RD
        f_valid = 1'b1;
        tick();
        chk("fl_rd_ena", 32'(bpu2rf_rs1_ena), 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_ena_gated", 32'(bpu2rf_rs1_ena), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_after_ena", 32'(bpu2rf_rs1_ena), 32'd0);
        chk("fl_after_wait", 32'(bpu_wait), 32'd1);
        f_valid = 1'b0;
        tick();

        // reset asserted while in DEP
        f_valid = 1'b1;
        oitf_empty = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_dep_state", 32'(dut.state_q), 32'(BPU_IDLE));
        chk("rst_dep_ena", 32'(bpu2rf_rs1_ena), 32'd0);
        rst = 1'b1;
        f_valid = 1'b0;
        oitf_empty = 1'b1;
        tick();

        // reset asserted while in RD drops ena asynchronously
        f_valid = 1'b1;
        tick();
        chk("rst_rd_pre_ena", 32'(bpu2rf_rs1_ena), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_rd_ena", 32'(bpu2rf_rs1_ena), 32'd0);
        rst = 1'b1;
        f_valid = 1'b0;
        tick();

        // jalr x0 at zero latency
        f_valid = 1'b1;
        dec_jalr_rs1idx = 5'd0;
        dec_bjp_imm = 32'h0000_0100;
        #1;
        chk("x0_wait", 32'(bpu_wait), 32'd0);
        chk("x0_pc", prdt_pc, 32'h0000_0100);
        chk("x0_taken", 32'(prdt_taken), 32'd1);
        f_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
